// File: rtl/ir_queue_if.sv
// Bus-side signal bundle for the instruction register / prefetch queue.
// The sequencer side uses the master modport and the queue uses the slave modport.
interface ir_queue_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int OPC_W = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                   ir_write;
   logic [WIDTH-1:0]       bus;
   logic                   ir_next;
   logic                   flush;
   logic [WIDTH-1:0]       ir_out;
   logic [OPC_W-1:0]       opcode;
   logic [WIDTH-OPC_W-1:0] operand;
   logic                   ir_valid;
   logic [CW-1:0]          count;
   logic                   full;
   logic                   empty;
   logic                   overflow;

   modport master (
      output ir_write, bus, ir_next, flush,
      input  ir_out, opcode, operand, ir_valid, count, full, empty, overflow
   );

   modport slave (
      input  ir_write, bus, ir_next, flush,
      output ir_out, opcode, operand, ir_valid, count, full, empty, overflow
   );
endinterface

// File: rtl/ir_queue.sv
// Instruction register fed by a DEPTH-entry circular prefetch FIFO.
// Fetch pushes bus words ahead of execute; the sequencer advances ir_out
// from the queue head, or straight from the bus when the queue is empty.
module ir_queue #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int OPC_W = 4
) (
   input logic       clk,
   input logic       rst,
   ir_queue_if.slave q
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] ir_out_q, ir_out_d;
   logic             ir_valid_q, ir_valid_d;
   logic             overflow_q, overflow_d;
   logic             pop, bypass, push_ok, push_drop, mem_we;

   // Classify this cycle's request: pop from queue, bus bypass, accepted or dropped push.
   // A full queue still accepts a push when a real pop frees the head slot;
   // the head is read before the write lands, since both share the same edge.
   always_comb begin
      pop       = q.ir_next && (count_q != '0);
      bypass    = q.ir_next && (count_q == '0) && q.ir_write;
      push_ok   = q.ir_write && !bypass && ((count_q != DEPTH_C) || pop);
      push_drop = q.ir_write && !bypass && !push_ok;
      mem_we    = push_ok && !q.flush && !rst;
   end

   // Next-state for pointers, count, ir_out, ir_valid and overflow; flush outranks push/advance.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ir_out_d   = ir_out_q;
      ir_valid_d = ir_valid_q;
      overflow_d = overflow_q;
      if (q.flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         ir_valid_d = 1'b0;
         overflow_d = 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            ir_out_d   = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PW'(1);
            ir_valid_d = 1'b1;
         end else if (bypass) begin
            ir_out_d   = q.bus;
            ir_valid_d = 1'b1;
         end else if (q.ir_next) begin
            ir_valid_d = 1'b0;
         end
         if (push_drop) begin
            overflow_d = 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control and instruction register state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ir_out_q   <= '0;
         ir_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ir_out_q   <= ir_out_d;
         ir_valid_q <= ir_valid_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage write; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= q.bus;
      end
   end

   assign q.ir_out   = ir_out_q;
   assign q.opcode   = ir_out_q[WIDTH-1 -: OPC_W];
   assign q.operand  = ir_out_q[WIDTH-OPC_W-1:0];
   assign q.ir_valid = ir_valid_q;
   assign q.count    = count_q;
   assign q.full     = (count_q == DEPTH_C);
   assign q.empty    = (count_q == '0);
   assign q.overflow = overflow_q;
endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with an integrated prefetch queue for the SAP datapath. Instruction words written from the shared bus are buffered in a DEPTH-entry circular FIFO. The control sequencer advances the current instruction register from the queue head on request. Opcode and operand fields are split out for the decoder, so fetch can run ahead of execute instead of stalling on a single holding register.

## Interface
Parameters:
- WIDTH, 16, instruction word width in bits
- DEPTH, 4, FIFO entries; a power of two, at least 2
- OPC_W, 4, opcode field width, taken from the MSBs; must be less than WIDTH

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- ir_write  input  1  push the bus word into the queue this cycle
- bus  input  WIDTH  shared data bus, sampled at the rising edge when ir_write=1
- ir_next  input  1  load the next instruction into ir_out
- flush  input  1  discard all queued words (branch/jump taken)
- ir_out  output  WIDTH  current instruction register
- opcode  output  OPC_W  ir_out[WIDTH-1 -: OPC_W], combinational
- operand  output  WIDTH-OPC_W  ir_out[WIDTH-OPC_W-1:0], combinational
- ir_valid  output  1  ir_out holds an instruction not yet superseded by an empty advance
- count  output  clog2(DEPTH+1)  number of queued words, excluding ir_out
- full  output  1  count==DEPTH, combinational from count
- empty  output  1  count==0, combinational from count
- overflow  output  1  sticky: a push was dropped because the queue was full

## Operation
- State: DEPTH x WIDTH storage, wr_ptr and rd_ptr (clog2(DEPTH) bits, wrap modulo DEPTH), count, ir_out, ir_valid, overflow.
- Priority per cycle: rst > flush > normal push/advance.
- Reset: ir_out=0, ir_valid=0, count=0, wr_ptr=rd_ptr=0, overflow=0. Storage contents are don't-care.
- Flush: count, wr_ptr and rd_ptr go to 0; ir_valid=0; overflow=0; ir_out holds its value. Concurrent ir_write and ir_next are ignored.
- Advance (ir_next=1):
  - Queue non-empty: ir_out <= storage[rd_ptr]; rd_ptr++; ir_valid=1.
  - Queue empty and ir_write=1 (bypass): ir_out <= bus; ir_valid=1; nothing is written into the FIFO; count stays 0.
  - Queue empty and ir_write=0: ir_out holds; ir_valid=0.
- Push (ir_write=1, not bypassed):
  - Accepted if count<DEPTH, or if count==DEPTH with a non-bypass pop in the same cycle (the pop frees the slot). Writes storage[wr_ptr]; wr_ptr++.
  - Otherwise the word is dropped, overflow is set to 1, and no state other than overflow changes from the push.
- Count update:
  - push accepted, no pop: +1
  - pop, no push: -1
  - push and pop together: unchanged
  - bypass: unchanged
- No advance and no push: all state holds. This is the same hold behaviour as a plain IR with its write enable low.
- Reads and writes never alias a live entry. With count==DEPTH and a simultaneous push+pop, the pop reads the old head before the slot is overwritten, because wr_ptr==rd_ptr only when full or empty.

## Timing
- All outputs change only at the rising edge of clk. The split fields, full and empty are combinational from registered state.
- Latency through the queue: push at edge N; earliest ir_next at edge N+1 delivers the word to ir_out at that edge (visible after N+1).
- Bypass latency: the bus word sampled at edge N appears on ir_out after edge N. This is identical to the single-register IR timing.
- count, full and empty reflect a push or pop after the edge that performs it.
- A reset or flush asserted mid-stream takes effect at that edge. Words pushed in the same cycle are lost, and do not set overflow.
- Throughput: one push and one advance per cycle, sustained indefinitely.

## Test plan
- Reset: hold rst for 2 cycles with ir_write=1, bus=16'hFFFF -> ir_out=0, ir_valid=0, count=0, empty=1, overflow=0.
- Bypass: from empty, ir_write=1, ir_next=1, bus=16'h3A5C for one cycle -> ir_out=16'h3A5C, opcode=4'h3, operand=12'hA5C, ir_valid=1, count=0.
- Fill and drain (DEPTH=4):
  - Push 16'h1001, 16'h2002, 16'h3003, 16'h4004 -> count=4, full=1.
  - Fifth push 16'h5005 -> dropped, overflow=1.
  - Four ir_next pulses -> ir_out sequence 1001, 2002, 3003, 4004.
  - Fifth ir_next -> ir_valid=0, ir_out still 16'h4004.
- Full with simultaneous push+pop: at count=4, ir_write=1, bus=16'h6006, ir_next=1 -> ir_out=16'h1001, count stays 4, overflow stays 0. Draining afterwards yields 2002, 3003, 4004, 6006.
- Wrap-around: run 10 cycles of back-to-back push+pop with increasing values starting at 16'h0100 -> ir_out follows input order exactly, pointers wrap, and count is constant at its starting value.
- Flush: with count=3 and ir_out=16'h1001, assert flush together with ir_write=1, bus=16'h7007 -> count=0, ir_valid=0, overflow=0, ir_out stays 16'h1001. A following ir_next with no write leaves ir_valid=0.
